// File: rtl/park_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : park_arbiter
//  Description : Round-robin scheduler that time-shares one inverse_park
//                datapath between NUM_CH current-loop channels. Grants one
//                request at a time, sequences the datapath start/done
//                handshake, returns alpha/beta over a per-channel valid/ready
//                response and aborts a transaction whose done never arrives.
//
//  Ports
//    clk, rst                      rising-edge clock, synchronous active-high reset
//    ch_valid / ch_ready           per-channel request handshake (ready one-hot)
//    ch_D, ch_Q, ch_sin, ch_cos    flattened operands, channel i at [i*D_WIDTH +: D_WIDTH]
//    rsp_valid / rsp_ready         per-channel response handshake (valid one-hot)
//    rsp_alpha, rsp_beta           shared result bus, stable while rsp_valid
//    park_start                    one-cycle start pulse to inverse_park
//    park_D/Q/sin/cos              operands to inverse_park, stable until done
//    park_alpha/beta, park_done    results and done pulse from inverse_park
//    busy                          high whenever a transaction is in flight
//    timeout_err                   one-cycle pulse when a transaction is aborted
//
//  Revision    : 1.0  initial release
// ============================================================================
module park_arbiter #(
    parameter int NUM_CH  = 2,   // 2..8
    parameter int D_WIDTH = 18,
    parameter int TIMEOUT = 64   // >= 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CH-1:0]                 ch_valid,
    output logic [NUM_CH-1:0]                 ch_ready,
    input  logic [NUM_CH*D_WIDTH-1:0]         ch_D,
    input  logic [NUM_CH*D_WIDTH-1:0]         ch_Q,
    input  logic [NUM_CH*D_WIDTH-1:0]         ch_sin,
    input  logic [NUM_CH*D_WIDTH-1:0]         ch_cos,
    output logic [NUM_CH-1:0]                 rsp_valid,
    input  logic [NUM_CH-1:0]                 rsp_ready,
    output logic signed [D_WIDTH-1:0]         rsp_alpha,
    output logic signed [D_WIDTH-1:0]         rsp_beta,
    output logic                              park_start,
    output logic signed [D_WIDTH-1:0]         park_D,
    output logic signed [D_WIDTH-1:0]         park_Q,
    output logic signed [D_WIDTH-1:0]         park_sin,
    output logic signed [D_WIDTH-1:0]         park_cos,
    input  logic signed [D_WIDTH-1:0]         park_alpha,
    input  logic signed [D_WIDTH-1:0]         park_beta,
    input  logic                              park_done,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_last;    // channel served (or aborted) most recently
    logic [GW-1:0]   r_grant;   // channel owning the current transaction
    logic [CW-1:0]   r_cnt;     // cycles elapsed since park_start

    logic            w_any;
    logic [GW-1:0]   w_pick;
    logic [NUM_CH-1:0] w_grant_oh;

    // Round-robin search starting just after r_last. The loop runs from the
    // farthest candidate to the nearest so the nearest valid channel wins.
    always_comb begin
        int idx;
        idx    = 0;
        w_any  = 1'b0;
        w_pick = r_last;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(r_last) + k) % NUM_CH;
            if (ch_valid[idx]) begin
                w_any  = 1'b1;
                w_pick = GW'(idx);
            end
        end
    end

    // Request accept is combinational so a channel sees it in the cycle the
    // grant is taken.
    always_comb begin
        ch_ready = '0;
        if (r_state == S_IDLE && w_any) begin
            ch_ready[w_pick] = 1'b1;
        end
    end

    always_comb begin
        w_grant_oh          = '0;
        w_grant_oh[r_grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= GW'(NUM_CH - 1);
            r_grant     <= '0;
            r_cnt       <= '0;
            park_start  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rsp_valid   <= '0;
            rsp_alpha   <= '0;
            rsp_beta    <= '0;
            park_D      <= '0;
            park_Q      <= '0;
            park_sin    <= '0;
            park_cos    <= '0;
        end else begin
            park_start  <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_pick;
                        park_D     <= ch_D[w_pick*D_WIDTH +: D_WIDTH];
                        park_Q     <= ch_Q[w_pick*D_WIDTH +: D_WIDTH];
                        park_sin   <= ch_sin[w_pick*D_WIDTH +: D_WIDTH];
                        park_cos   <= ch_cos[w_pick*D_WIDTH +: D_WIDTH];
                        park_start <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The start-pulse cycle counts as the first elapsed cycle,
                    // so the abort pulse lands exactly TIMEOUT cycles after
                    // park_start.
                    r_cnt   <= CW'(1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (park_done) begin
                        rsp_alpha <= park_alpha;
                        rsp_beta  <= park_beta;
                        rsp_valid <= w_grant_oh;
                        r_state   <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        r_last      <= r_grant;
                        busy        <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[r_grant]) begin
                        rsp_valid <= '0;
                        r_last    <= r_grant;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/park_arbiter.md
Name: park_arbiter

Overview:
- Round-robin scheduler that shares one inverse_park datapath instance between NUM_CH current-loop channels.
- Each channel supplies a transform request as D, Q, sin and cos. The arbiter grants one request at a time and sequences the datapath through its start/done handshake.
- It returns alpha and beta to the granted channel over a valid/ready response.
- A watchdog aborts any transaction whose done never arrives.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- D_WIDTH, 18, signed operand/result width; matches inverse_park D_WIDTH.
- TIMEOUT, 64, maximum cycles in WAIT before the transaction is aborted.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- ch_valid  in  NUM_CH  per-channel request valid.
- ch_ready  out  NUM_CH  per-channel request accept; one-hot or zero.
- ch_D  in  NUM_CH*D_WIDTH  flattened D operands; channel i occupies bits [i*D_WIDTH +: D_WIDTH].
- ch_Q  in  NUM_CH*D_WIDTH  flattened Q operands.
- ch_sin  in  NUM_CH*D_WIDTH  flattened sin operands.
- ch_cos  in  NUM_CH*D_WIDTH  flattened cos operands.
- rsp_valid  out  NUM_CH  per-channel response valid; one-hot or zero.
- rsp_ready  in  NUM_CH  per-channel response ready.
- rsp_alpha  out  D_WIDTH  result alpha; shared by all channels.
- rsp_beta  out  D_WIDTH  result beta; shared by all channels.
- park_start  out  1  start pulse to inverse_park.
- park_D, park_Q, park_sin, park_cos  out  D_WIDTH each  operands to inverse_park.
- park_alpha, park_beta  in  D_WIDTH each  results from inverse_park.
- park_done  in  1  inverse_park done pulse.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse when a transaction is aborted.

Behaviour:
- Reset:
  - ch_ready, rsp_valid, park_start, busy, timeout_err = 0.
  - park_* operand outputs, rsp_alpha and rsp_beta = 0.
  - State = IDLE, last_grant = NUM_CH-1 so channel 0 has top priority after reset.
  - Reset asserted in any state aborts the transaction with no response and no error pulse.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. WAIT can also exit to IDLE on timeout.
- IDLE:
  - If any ch_valid is high, grant g = the first valid channel searching last_grant+1, +2, ... modulo NUM_CH.
  - Drive ch_ready[g]=1 combinationally in the same cycle.
  - Register channel g's D, Q, sin and cos onto park_*; go to ISSUE.
  - With no valid request, ch_ready = 0 and the state is held.
- ISSUE:
  - park_start = 1 for exactly one cycle; operands are already stable.
  - Clear the watchdog count; go to WAIT.
- WAIT:
  - park_* operands are held constant until WAIT exits.
  - On park_done: capture park_alpha/park_beta into rsp_alpha/rsp_beta; go to RESP.
  - Otherwise, when the count reaches TIMEOUT-1: pulse timeout_err, set last_grant = g, go to IDLE, produce no response.
- RESP:
  - rsp_valid[g] = 1; rsp_alpha/rsp_beta are held stable.
  - On rsp_ready[g] (the cycle of the handshake): set last_grant = g, go to IDLE. The next grant may be issued on the following cycle.
  - rsp_ready of non-granted channels is ignored.
- park_done outside WAIT is ignored and does not change state.
- Width rules: no arithmetic in this block; operands and results pass bit-exact, signed D_WIDTH.
- Fairness: a channel holding ch_valid continuously waits at most NUM_CH-1 other transactions.
- Throughput: one transaction takes 1 (IDLE) + 1 (ISSUE) + datapath latency + 1 (RESP minimum) cycles.
- Request rules for channels:
  - A channel must hold ch_valid and its operands stable until ch_ready.
  - Deasserting ch_valid before grant withdraws the request.

Test Plan:
- Single request: ch0 with D=27426 (0.837*2^15), Q=0, sin=cos=23167 against an inverse_park model -> one park_start pulse 2 cycles after ch_valid; rsp_valid[0] with alpha=19390, beta=19390; busy low afterwards.
- Contention: ch0 and ch1 both valid continuously; ch0 D=-30376, Q=22971; ch1 D=-20683, Q=-14752 -> grants alternate 0,1,0,1; each response lands on the correct rsp_valid bit with the model's alpha/beta.
- Response backpressure: rsp_ready[1] held low 10 cycles -> rsp_valid[1], rsp_alpha and rsp_beta stable for 10 cycles; no new park_start issued until the handshake.
- Timeout: model never asserts park_done -> timeout_err pulses exactly TIMEOUT cycles after park_start; no rsp_valid; the next grant goes to the other channel.
- Spurious done: park_done pulsed while in IDLE and while in RESP -> no state change, results not overwritten.
- Reset mid-WAIT: rst asserted one cycle -> all outputs 0 next cycle; the following request from ch1 while ch0 is also valid grants ch0 first.
